// File: rtl/on_chip_with_keyboard_pio_keyin.sv
// on_chip_with_keyboard_pio_keyin: Avalon-MM input PIO with edge capture, maskable IRQ and saturating change counter; define KEYIN_EDGE_W1C_EN for write-1-to-clear edgecapture
module on_chip_with_keyboard_pio_keyin #(
    parameter int DATA_WIDTH = 32,
    parameter int EDGE_TYPE  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);
    logic [DATA_WIDTH-1:0] r_sync1, r_sync2, r_prev, r_irqmask, r_edgecap;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  w_wr, w_change;
    logic [DATA_WIDTH-1:0] w_edge, w_ec_clr;

    // edge selection from the synchronized history and per-bit clear mask for edgecapture writes
    always_comb begin
        w_wr     = chipselect & ~write_n;
        w_change = |(r_sync2 ^ r_prev);
        w_edge   = (EDGE_TYPE == 0) ? (r_sync2 & ~r_prev) :
                   (EDGE_TYPE == 1) ? (~r_sync2 & r_prev) : (r_sync2 ^ r_prev);
`ifdef KEYIN_EDGE_W1C_EN
        w_ec_clr = (w_wr && address == 2'd2) ? writedata[DATA_WIDTH-1:0] : '0;
`else
        w_ec_clr = {DATA_WIDTH{w_wr && address == 2'd2}};
`endif
    end

    // synchronizer, sticky edge bits (set beats clear), mask register and saturating change counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_irqmask <= '0;
            r_edgecap <= '0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= in_port;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_edgecap <= (r_edgecap & ~w_ec_clr) | w_edge;
            if (w_wr && address == 2'd1)
                r_irqmask <= writedata[DATA_WIDTH-1:0];
            if (w_wr && address == 2'd3)
                r_cnt <= CNT_WIDTH'(w_change);
            else if (w_change && r_cnt != '1)
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    // zero-wait-state read mux and level interrupt straight from registers
    always_comb begin
        irq      = |(r_edgecap & r_irqmask);
        readdata = (address == 2'd0) ? 32'(r_sync2)   :
                   (address == 2'd1) ? 32'(r_irqmask) :
                   (address == 2'd2) ? 32'(r_edgecap) : 32'(r_cnt);
    end
endmodule

// File: tb/tb_on_chip_with_keyboard_pio_keyin.sv
// tb_on_chip_with_keyboard_pio_keyin: directed checks of the keyin PIO across edge types and a narrow counter
module tb_on_chip_with_keyboard_pio_keyin;
    logic        clk = 0;
    logic        reset_n = 1;
    logic [1:0]  address = 0;
    logic        chipselect = 0;
    logic        write_n = 1;
    logic [31:0] writedata = 0;
    logic [31:0] in_port = 0;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;
    int          pass = 0;
    int          total = 0;
    logic [31:0] v;
    logic [31:0] ec_exp;

    always #5 clk = ~clk;

    on_chip_with_keyboard_pio_keyin dut0 (.clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));
    on_chip_with_keyboard_pio_keyin #(.EDGE_TYPE(1)) dut1 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));
    on_chip_with_keyboard_pio_keyin #(.EDGE_TYPE(2)) dut2 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));
    on_chip_with_keyboard_pio_keyin #(.CNT_WIDTH(4)) dut3 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata), .readdata(rd3), .in_port(in_port), .irq(irq3));

    task automatic peek(input int d, input logic [1:0] a, output logic [31:0] r);
        address = a;
        #1;
        r = (d == 0) ? rd0 : (d == 1) ? rd1 : (d == 2) ? rd2 : rd3;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1; write_n = 0;
        @(negedge clk);
        chipselect = 0; write_n = 1;
    endtask

    task automatic do_reset(input logic [31:0] pin);
        @(negedge clk);
        in_port = pin; chipselect = 0; write_n = 1;
        #2 reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset(0);
        wait_neg(1);
        for (int a = 0; a < 4; a++) begin
            peek(0, 2'(a), v);
            total++; if (v !== 32'h0) $display("FAIL reset_addr%0d: got %h want %h", a, v, 32'h0); else pass++;
        end
        wait_neg(1);
        total++; if (irq0 !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq0); else pass++;
    endtask

    task automatic test_rising_irq;
        do_reset(0);
        wr(1, 32'h1);
        in_port = 32'h1;
        wait_neg(2);
        peek(0, 0, v);
        total++; if (v !== 32'h1) $display("FAIL rise_data: got %h want %h", v, 32'h1); else pass++;
        peek(0, 2, v);
        total++; if (v !== 32'h0) $display("FAIL rise_ec_early: got %h want %h", v, 32'h0); else pass++;
        total++; if (irq0 !== 1'b0) $display("FAIL rise_irq_early: got %b want 0", irq0); else pass++;
        wait_neg(1);
        peek(0, 2, v);
        total++; if (v !== 32'h1) $display("FAIL rise_ec: got %h want %h", v, 32'h1); else pass++;
        total++; if (irq0 !== 1'b1) $display("FAIL rise_irq: got %b want 1", irq0); else pass++;
        peek(0, 3, v);
        total++; if (v !== 32'h1) $display("FAIL rise_cnt: got %h want %h", v, 32'h1); else pass++;
        peek(0, 1, v);
        total++; if (v !== 32'h1) $display("FAIL rise_mask: got %h want %h", v, 32'h1); else pass++;
    endtask

    task automatic test_mask_clear;
        do_reset(0);
        wr(1, 32'h1);
        in_port = 32'h6;
        wait_neg(3);
        peek(0, 2, v);
        total++; if (v !== 32'h6) $display("FAIL mask_ec: got %h want %h", v, 32'h6); else pass++;
        total++; if (irq0 !== 1'b0) $display("FAIL mask_irq: got %b want 0", irq0); else pass++;
        peek(0, 3, v);
        total++; if (v !== 32'h1) $display("FAIL mask_cnt: got %h want %h", v, 32'h1); else pass++;
        wr(2, 32'h4);
`ifdef KEYIN_EDGE_W1C_EN
        ec_exp = 32'h2;
`else
        ec_exp = 32'h0;
`endif
        peek(0, 2, v);
        total++; if (v !== ec_exp) $display("FAIL clear_ec: got %h want %h", v, ec_exp); else pass++;
    endtask

    task automatic test_set_wins;
        do_reset(0);
        in_port = 32'h2;
        wait_neg(4);
        peek(0, 2, v);
        total++; if (v !== 32'h2) $display("FAIL setwin_pre: got %h want %h", v, 32'h2); else pass++;
        @(negedge clk);
        in_port = 32'h3;
        wait_neg(2);
        address = 2; writedata = 32'hFFFF_FFFF; chipselect = 1; write_n = 0;
        @(negedge clk);
        chipselect = 0; write_n = 1;
        peek(0, 2, v);
        total++; if (v !== 32'h1) $display("FAIL setwin_ec: got %h want %h", v, 32'h1); else pass++;
    endtask

    task automatic test_edge_types;
        do_reset(0);
        in_port = 32'h1;
        wait_neg(4);
        peek(1, 2, v);
        total++; if (v !== 32'h0) $display("FAIL fall_on_rise: got %h want %h", v, 32'h0); else pass++;
        peek(2, 2, v);
        total++; if (v !== 32'h1) $display("FAIL any_on_rise: got %h want %h", v, 32'h1); else pass++;
        wr(2, 32'hFFFF_FFFF);
        wr(3, 32'h0);
        @(negedge clk);
        in_port = 32'h0;
        wait_neg(3);
        peek(1, 2, v);
        total++; if (v !== 32'h1) $display("FAIL fall_ec: got %h want %h", v, 32'h1); else pass++;
        peek(2, 2, v);
        total++; if (v !== 32'h1) $display("FAIL any_ec_fall: got %h want %h", v, 32'h1); else pass++;
        wr(2, 32'hFFFF_FFFF);
        @(negedge clk);
        in_port = 32'h1;
        wait_neg(3);
        peek(1, 2, v);
        total++; if (v !== 32'h0) $display("FAIL fall_ec_rise: got %h want %h", v, 32'h0); else pass++;
        peek(2, 2, v);
        total++; if (v !== 32'h1) $display("FAIL any_ec_rise: got %h want %h", v, 32'h1); else pass++;
        peek(1, 3, v);
        total++; if (v !== 32'h2) $display("FAIL fall_cnt: got %h want %h", v, 32'h2); else pass++;
        peek(2, 3, v);
        total++; if (v !== 32'h2) $display("FAIL any_cnt: got %h want %h", v, 32'h2); else pass++;
    endtask

    task automatic test_counter;
        do_reset(0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_port[0] = ~in_port[0];
        end
        wait_neg(4);
        peek(3, 3, v);
        total++; if (v !== 32'hF) $display("FAIL cnt_sat: got %h want %h", v, 32'hF); else pass++;
        peek(0, 3, v);
        total++; if (v !== 32'd20) $display("FAIL cnt_wide: got %h want %h", v, 32'd20); else pass++;
        @(negedge clk);
        in_port[0] = ~in_port[0];
        wait_neg(2);
        address = 3; writedata = 32'h0; chipselect = 1; write_n = 0;
        @(negedge clk);
        chipselect = 0; write_n = 1;
        peek(3, 3, v);
        total++; if (v !== 32'h1) $display("FAIL cnt_clr_chg: got %h want %h", v, 32'h1); else pass++;
        wr(3, 32'h0);
        peek(3, 3, v);
        total++; if (v !== 32'h0) $display("FAIL cnt_clr: got %h want %h", v, 32'h0); else pass++;
    endtask

    task automatic test_async_reset;
        do_reset(0);
        wr(1, 32'h1);
        in_port = 32'h1;
        wait_neg(3);
        total++; if (irq0 !== 1'b1) $display("FAIL arst_pre_irq: got %b want 1", irq0); else pass++;
        #2 reset_n = 0;
        #1;
        total++; if (irq0 !== 1'b0) $display("FAIL arst_irq: got %b want 0", irq0); else pass++;
        peek(0, 2, v);
        total++; if (v !== 32'h0) $display("FAIL arst_ec: got %h want %h", v, 32'h0); else pass++;
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        test_reset;
        test_rising_irq;
        test_mask_clear;
        test_set_wins;
        test_edge_types;
        test_counter;
        test_async_reset;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
